// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory request/grant/response bus
//   req    fetch request, held until gnt
//   addr   fetch address
//   gnt    memory accepted the request
//   rvalid rdata is valid
//   rdata  fetched instruction word
interface pc_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, addr, input gnt, rvalid, rdata);
  modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction fetch stage of the one-tact MIPS core
//   clk, rst_n      clock, asynchronous active-low reset
//   imem            instruction-memory bus (master side)
//   pc_next_c_i     next-PC select: 00 pc+4, 01 branch, 1x jump
//   imm_i, jidx_i   branch offset and jump index of the current instruction
//   halt_i          stop after the instruction in execute
//   instr_o         registered instruction, instr_valid_o high in execute
//   pc_o, pc_plus4_o current PC and PC+4
//   halted_o        halted state, retired_o executed-instruction count
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_fetch_if.master  imem,
  input  logic [1:0]  pc_next_c_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] jidx_i,
  input  logic        halt_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        halted_o,
  output logic [31:0] retired_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, HALTED} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, retired_q, retired_d, pc_sel;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign pc_sel        = pc_next_c_i[1] ? {pc_plus4_o[31:28], jidx_i, 2'b00} :
                         pc_next_c_i[0] ? pc_plus4_o + {{14{imm_i[15]}}, imm_i, 2'b00} :
                         pc_plus4_o;
  assign imem.req      = state_q == REQ;
  assign imem.addr     = pc_q;
  assign instr_valid_o = state_q == EXEC;
  assign halted_o      = state_q == HALTED;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign retired_o     = retired_q;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = imem.gnt ? WAIT : REQ;
      WAIT: begin
        state_d = imem.rvalid ? EXEC : WAIT;
        instr_d = imem.rvalid ? imem.rdata : instr_q;
      end
      EXEC: begin
        state_d   = halt_i ? HALTED : REQ;
        pc_d      = pc_sel;
        retired_d = retired_q + 32'd1;
      end
      default: state_d = HALTED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed and randomized checks of pc_fetch against a next-PC model
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_next_c_i = '0;
  logic [15:0] imm_i = '0;
  logic [25:0] jidx_i = '0;
  logic        halt_i = 1'b0;
  logic [31:0] instr_o, pc_o, pc_plus4_o, retired_o;
  logic        instr_valid_o, halted_o;
  logic [31:0] exp_pc, exp_ret, exp_instr;
  int          total = 0;
  int          bad = 0;
  pc_fetch_if bus();
  pc_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus.master),
    .pc_next_c_i(pc_next_c_i), .imm_i(imm_i), .jidx_i(jidx_i), .halt_i(halt_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .pc_o(pc_o),
    .pc_plus4_o(pc_plus4_o), .halted_o(halted_o), .retired_o(retired_o)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic logic [31:0] npc(input logic [31:0] p, input logic [1:0] s,
                                      input logic [15:0] im, input logic [25:0] ji);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (s[1]) return {p4[31:28], ji, 2'b00};
    if (s[0]) return p4 + 32'(4 * int'($signed(im)));
    return p4;
  endfunction
  task automatic scramble;
    halt_i      = 1'($urandom);
    pc_next_c_i = 2'($urandom);
    imm_i       = 16'($urandom);
    jidx_i      = 26'($urandom);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_halted", 32'(halted_o), 32'd0);
    check("rst_retired", retired_o, 32'h0);
    step;
    rst_n = 1'b1;
    step;
    exp_pc = 32'h0;
    exp_ret = 32'h0;
    exp_instr = 32'h0;
  endtask
  task automatic fetch(input int gd, input int rd, input logic [1:0] sel, input logic [15:0] im,
                       input logic [25:0] ji, input logic h, input logic [31:0] w);
    check("req", 32'(bus.req), 32'd1);
    check("addr", bus.addr, exp_pc);
    for (int i = 0; i < gd; i++) begin
      bus.gnt = 1'b0;
      bus.rvalid = 1'($urandom);
      bus.rdata = $urandom;
      scramble();
      step;
      check("req_gstall", 32'(bus.req), 32'd1);
      check("addr_gstall", bus.addr, exp_pc);
      check("pc_gstall", pc_o, exp_pc);
      check("instr_gstall", instr_o, exp_instr);
    end
    bus.gnt = 1'b1;
    bus.rvalid = 1'($urandom);
    bus.rdata = $urandom;
    scramble();
    step;
    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
    check("req_wait", 32'(bus.req), 32'd0);
    for (int i = 0; i < rd; i++) begin
      scramble();
      bus.gnt = 1'($urandom);
      step;
      bus.gnt = 1'b0;
      check("req_rstall", 32'(bus.req), 32'd0);
      check("valid_rstall", 32'(instr_valid_o), 32'd0);
      check("pc_rstall", pc_o, exp_pc);
      check("instr_rstall", instr_o, exp_instr);
    end
    bus.rvalid = 1'b1;
    bus.rdata = w;
    step;
    bus.rvalid = 1'b0;
    bus.rdata = $urandom;
    pc_next_c_i = sel;
    imm_i = im;
    jidx_i = ji;
    halt_i = h;
    exp_instr = w;
    check("valid_exec", 32'(instr_valid_o), 32'd1);
    check("instr_exec", instr_o, w);
    check("pc_exec", pc_o, exp_pc);
    check("pc_plus4", pc_plus4_o, exp_pc + 32'd4);
    exp_pc = npc(exp_pc, sel, im, ji);
    exp_ret = exp_ret + 32'd1;
    step;
    halt_i = 1'b0;
    check("valid_after", 32'(instr_valid_o), 32'd0);
    check("pc_next", pc_o, exp_pc);
    check("retired", retired_o, exp_ret);
    check("halted", 32'(halted_o), 32'(h));
    check("req_after", 32'(bus.req), 32'(!h));
  endtask
  initial begin
    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      check("seq_addr", bus.addr, 32'(4 * k));
      fetch(0, 0, 2'b00, 16'h0, 26'h0, 1'b0, 32'h1000 + 32'(k));
    end
    check("seq_retired", retired_o, 32'd4);
    fetch(0, 0, 2'b10, 16'h0, 26'h40, 1'b0, 32'h0800_0040);
    check("jump_to_100", pc_o, 32'h100);
    fetch(0, 0, 2'b01, 16'hFFFF, 26'h0, 1'b0, 32'h1000_FFFF);
    check("branch_m1", pc_o, 32'h100);
    fetch(0, 0, 2'b01, 16'h0003, 26'h0, 1'b0, 32'h1000_0003);
    check("branch_p3", pc_o, 32'h110);
    fetch(3, 2, 2'b00, 16'h0, 26'h0, 1'b0, 32'hCAFE_F00D);
    check("stall_instr", instr_o, 32'hCAFE_F00D);
    check("stall_retired", retired_o, 32'd8);
    for (int k = 0; k < 30; k++)
      fetch($urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), 16'($urandom),
            26'($urandom), 1'b0, $urandom);
    do_reset();
    fetch(1, 1, 2'b01, 16'hFFFE, 26'h0, 1'b0, 32'h1);
    check("to_fffffffc", pc_o, 32'hFFFF_FFFC);
    fetch(0, 0, 2'b00, 16'h0, 26'h0, 1'b0, 32'h2);
    check("pc_wrap", pc_o, 32'h0);
    fetch(0, 0, 2'b10, 16'h0, 26'h3FF_FFFF, 1'b0, 32'h3);
    check("to_0ffffffc", pc_o, 32'h0FFF_FFFC);
    fetch(0, 0, 2'b10, 16'h0, 26'h000_0010, 1'b0, 32'h4);
    check("to_10000040", pc_o, 32'h1000_0040);
    fetch(2, 1, 2'b11, 16'h1234, 26'h000_0010, 1'b0, 32'h5);
    check("jump_priority", pc_o, 32'h1000_0040);
    fetch(0, 0, 2'b00, 16'h0, 26'h0, 1'b1, 32'h6);
    for (int k = 0; k < 4; k++) begin
      bus.gnt = 1'b1;
      bus.rvalid = 1'($urandom);
      scramble();
      step;
      check("halt_halted", 32'(halted_o), 32'd1);
      check("halt_req", 32'(bus.req), 32'd0);
      check("halt_pc", pc_o, 32'h1000_0044);
      check("halt_retired", retired_o, exp_ret);
    end
    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
    halt_i = 1'b0;
    do_reset();
    fetch(0, 0, 2'b10, 16'h0, 26'h80, 1'b0, 32'h7);
    check("pre_mid_pc", pc_o, 32'h200);
    bus.gnt = 1'b1;
    step;
    bus.gnt = 1'b0;
    check("mid_req_wait", 32'(bus.req), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_pc_async", pc_o, 32'h0);
    check("mid_instr_async", instr_o, 32'h0);
    check("mid_retired_async", retired_o, 32'h0);
    step;
    rst_n = 1'b1;
    step;
    bus.rvalid = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    check("mid_req", 32'(bus.req), 32'd1);
    check("mid_addr", bus.addr, 32'h0);
    step;
    bus.rvalid = 1'b0;
    check("mid_instr", instr_o, 32'h0);
    check("mid_valid", 32'(instr_valid_o), 32'd0);
    exp_pc = 32'h0;
    exp_ret = 32'h0;
    exp_instr = 32'h0;
    fetch(0, 0, 2'b00, 16'h0, 26'h0, 1'b0, 32'h8);
    check("post_mid_pc", pc_o, 32'h4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
